// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB full-speed receive decoder.
package usb_rx_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int STUFF_LEN_DEF   = 6;
  localparam int EOP_SE0_MIN_DEF = 2;
  localparam int IDLE_J_CNT_DEF  = 7;

  // Decoded SYNC (KJKJKJKK), oldest bit in the MSB.
  localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;

  typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC_HUNT,
    ST_RX_DATA,
    ST_EOP,
    ST_ERROR
  } rx_dec_state_t;

  function automatic line_state_t decode_line(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return J;
      2'b01:   return K;
      2'b00:   return SE0;
      default: return SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decode plus bit-unstuffing; ones counting runs only while enable is high.
module usb_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
)(
  input  logic        clk,
  input  logic        nRST,
  input  line_state_t line,
  input  logic        bit_strobe,
  input  logic        enable,
  output logic        dec_bit,
  output logic        bit_valid,
  output logic        stuff_err
);

  localparam int OW = $clog2(STUFF_LEN + 1);

  line_state_t   prev_q;
  logic [OW-1:0] ones_q;
  logic          is_jk;
  logic          at_lim;

  assign is_jk     = (line == J) || (line == K);
  assign at_lim    = (ones_q == OW'(STUFF_LEN));
  assign dec_bit   = (line == prev_q);
  // At the limit the bit is either the mandatory stuffed 0 or a violation.
  assign bit_valid = is_jk && !(enable && at_lim);
  assign stuff_err = enable && is_jk && at_lim && dec_bit;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      prev_q <= J;
      ones_q <= '0;
    end else if (bit_strobe) begin
      if (is_jk) prev_q <= line;
      if (!enable || !is_jk || at_lim || !dec_bit) ones_q <= '0;
      else                                         ones_q <= ones_q + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB FS receive front-end: SYNC hunt, LSB-first byte assembly, EOP/error handling.
// Define USB_RX_PID_CHECK_EN to check the first byte after SYNC as a PID.
module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int STUFF_LEN   = STUFF_LEN_DEF,
  parameter int EOP_SE0_MIN = EOP_SE0_MIN_DEF,
  parameter int IDLE_J_CNT  = IDLE_J_CNT_DEF
)(
  input  logic              clk,
  input  logic              nRST,
  input  logic              bit_strobe,
  input  logic              dp,
  input  logic              dm,
  output logic [DATA_W-1:0] rx_data,
  output logic              RXValid,
  output logic              RXActive,
  output logic              RXError,
  output logic              SYNC_Detected,
  output logic              EOP_Detected
);

  localparam int SYNC_W = $bits(SYNC_PATTERN);
  localparam int CW     = $clog2((DATA_W > SYNC_W ? DATA_W : SYNC_W) + 1);
  localparam int SW     = $clog2(EOP_SE0_MIN + 1);
  localparam int JW     = $clog2(IDLE_J_CNT + 1);

  line_state_t   line;
  logic          dec_bit, bit_valid, stuff_err;

  rx_dec_state_t state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_d, data_n;
  logic [SYNC_W-1:0] sync_q, sync_d, sync_n;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] se0_q, se0_d;
  logic [JW-1:0] jcnt_q, jcnt_d;
  logic          active_d, valid_d, err_d, sync_det_d, eop_det_d, go_err;
`ifdef USB_RX_PID_CHECK_EN
  logic          first_q, first_d;
`endif

  assign line = decode_line(dp, dm);

  usb_nrzi_unstuff #(.STUFF_LEN(STUFF_LEN)) u_nrzi (
    .clk       (clk),
    .nRST      (nRST),
    .line      (line),
    .bit_strobe(bit_strobe),
    .enable    (state_q == ST_RX_DATA),
    .dec_bit   (dec_bit),
    .bit_valid (bit_valid),
    .stuff_err (stuff_err)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    sync_d     = sync_q;
    bit_cnt_d  = bit_cnt_q;
    se0_d      = se0_q;
    jcnt_d     = jcnt_q;
    data_d     = rx_data;
    active_d   = RXActive;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    sync_det_d = 1'b0;
    eop_det_d  = 1'b0;
    go_err     = 1'b0;
`ifdef USB_RX_PID_CHECK_EN
    first_d    = first_q;
`endif
    sync_n = {sync_q[SYNC_W-2:0], dec_bit};
    data_n = {dec_bit, shift_q[DATA_W-1:1]};
    if (bit_strobe) begin
      case (state_q)
        ST_IDLE: if (line == K) begin
          state_d   = ST_SYNC_HUNT;
          sync_d    = '0;
          bit_cnt_d = CW'(1);
        end
        ST_SYNC_HUNT: begin
          if (line == SE0 || line == SE1) begin
            state_d = ST_IDLE;
          end else if (bit_cnt_q == CW'(SYNC_W - 1)) begin
            bit_cnt_d = '0;
            if (sync_n == SYNC_PATTERN) begin
              sync_det_d = 1'b1;
              active_d   = 1'b1;
              state_d    = ST_RX_DATA;
`ifdef USB_RX_PID_CHECK_EN
              first_d    = 1'b1;
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            sync_d    = sync_n;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_RX_DATA: begin
          if (line == SE0) begin
            state_d = ST_EOP;
            se0_d   = SW'(1);
          end else if (line == SE1 || stuff_err) begin
            go_err = 1'b1;
          end else if (bit_valid) begin
            shift_d = data_n;
            if (bit_cnt_q == CW'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              data_d    = data_n;
              valid_d   = 1'b1;
`ifdef USB_RX_PID_CHECK_EN
              // PID byte: upper nibble must be the complement of the lower.
              if (first_q) begin
                first_d = 1'b0;
                if (data_n[7:4] != ~data_n[3:0]) err_d = 1'b1;
              end
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_EOP: begin
          if (line == SE0) begin
            if (se0_q != SW'(EOP_SE0_MIN)) se0_d = se0_q + 1'b1;
          end else if (line == J && se0_q >= SW'(EOP_SE0_MIN)) begin
            eop_det_d = 1'b1;
            active_d  = 1'b0;
            err_d     = (bit_cnt_q != '0);
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            go_err = 1'b1;
          end
        end
        ST_ERROR: begin
          // se0_q doubles as "previous bit was SE0" while in ERROR.
          if (line == J && (se0_q != '0 || jcnt_q == JW'(IDLE_J_CNT - 1))) begin
            state_d   = ST_IDLE;
            active_d  = 1'b0;
            bit_cnt_d = '0;
          end
          se0_d  = SW'(line == SE0);
          jcnt_d = (line == J) ? jcnt_q + 1'b1 : '0;
        end
        default: state_d = ST_IDLE;
      endcase
      if (go_err) begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
        se0_d   = '0;
        jcnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      sync_q        <= '0;
      bit_cnt_q     <= '0;
      se0_q         <= '0;
      jcnt_q        <= '0;
      rx_data       <= '0;
      RXActive      <= 1'b0;
      RXValid       <= 1'b0;
      RXError       <= 1'b0;
      SYNC_Detected <= 1'b0;
      EOP_Detected  <= 1'b0;
`ifdef USB_RX_PID_CHECK_EN
      first_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      sync_q        <= sync_d;
      bit_cnt_q     <= bit_cnt_d;
      se0_q         <= se0_d;
      jcnt_q        <= jcnt_d;
      rx_data       <= data_d;
      RXActive      <= active_d;
      RXValid       <= valid_d;
      RXError       <= err_d;
      SYNC_Detected <= sync_det_d;
      EOP_Detected  <= eop_det_d;
`ifdef USB_RX_PID_CHECK_EN
      first_q       <= first_d;
`endif
    end
  end

endmodule
